video_render_mx: RTL

Pipelined, parametrised pixel renderer that replaces the single-layer combinational renderer in the video path. It decodes the fetched graphics word in ZX, 16c, 256c, text or 4c mode and composites it with NLAYERS tile/sprite layers at a programmable priority position. It generates the ZX flash phase internally and packs 1, 2 or 4 pixels per output byte for normal, hi-res and super-hi-res plex.
Output feeds the video plex/palette stage.

---
 rtl/video_render_mx.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/video_render_mx.sv
`default_nettype none
// ============================================================================
// Module      : video_render_mx
// Description : Two-stage pixel renderer. Stage 1 decodes the fetched gfx
//               word (ZX / 16c / 256c / text / 4c) and aligns the side-band
//               inputs with their pixel. Stage 2 composites gfx with the TS
//               layers at a programmable stack position and packs 1, 2 or 4
//               pixels per output byte. Also owns the ZX flash phase.
// Revision    : 1.0 - initial release
// ============================================================================
module video_render_mx #(
    parameter int NLAYERS   = 2,
    parameter int FLASH_DIV = 16,
    parameter int PRIO_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c1,
    input  logic                 frame_start,
    input  logic                 line_start,
    input  logic                 hvpix,
    input  logic                 hvtspix,
    input  logic                 nogfx,
    input  logic [2:0]           render_mode,
    input  logic [3:0]           psel,
    input  logic [3:0]           palsel,
    input  logic [1:0]           hires_mode,
    input  logic [PRIO_W-1:0]    gfx_prio,
    input  logic [NLAYERS-1:0]   ts_en,
    input  logic [8*NLAYERS-1:0] ts_data,
    input  logic [31:0]          data,
    input  logic [7:0]           border_in,
    output logic [7:0]           vplex_out,
    output logic                 vplex_valid,
    output logic                 flash_out
);

    localparam int                FC_W    = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FLASH_DIV - 1);
    localparam logic [PRIO_W-1:0] GFX_MAX = PRIO_W'(NLAYERS);

    // ---------------- decode ----------------
    logic       dot;
    logic [7:0] attr;
    logic [3:0] nib;
    logic [7:0] px_byte;
    logic [7:0] quad_byte;
    logic [1:0] dot2;
    logic [7:0] dec_pix;
    logic       dec_pv;
    logic       dec_ok;
    logic [1:0] hires_eff;

    // Per-mode pixel decode of the fetched word
    always_comb begin
        dot       = data[{1'b0, psel[3], ~psel[2:0]}];
        attr      = psel[3] ? data[31:24] : data[23:16];
        px_byte   = psel[0] ? data[15:8] : data[7:0];
        quad_byte = psel[2] ? data[15:8] : data[7:0];
        case (psel[1:0])
            2'd0:    nib = data[7:4];
            2'd1:    nib = data[3:0];
            2'd2:    nib = data[15:12];
            default: nib = data[11:8];
        endcase
        // 4c dots are MSB-first within each byte
        case (psel[1:0])
            2'd0:    dot2 = quad_byte[7:6];
            2'd1:    dot2 = quad_byte[5:4];
            2'd2:    dot2 = quad_byte[3:2];
            default: dot2 = quad_byte[1:0];
        endcase
        dec_pv  = 1'b0;
        dec_pix = 8'h00;
        dec_ok  = 1'b1;
        case (render_mode)
            3'd0: begin
                dec_pv  = dot ^ (flash_out & attr[7]);
                dec_pix = {palsel, attr[6], dec_pv ? attr[2:0] : attr[5:3]};
            end
            3'd1: begin
                dec_pv  = |nib;
                dec_pix = {palsel, nib};
            end
            3'd2: begin
                dec_pv  = |px_byte;
                dec_pix = px_byte;
            end
            3'd3: begin
                dec_pv  = dot;
                dec_pix = {palsel, dot ? attr[3:0] : attr[7:4]};
            end
            3'd4: begin
                dec_pv  = |dot2;
                dec_pix = {palsel, 2'b00, dot2};
            end
            default: dec_ok = 1'b0;
        endcase
        hires_eff = (hires_mode == 2'd3) ? 2'd0 : hires_mode;
    end

    // ---------------- stage 1 registers ----------------
    logic                 s1_valid;
    logic [7:0]           s1_pix;
    logic                 s1_pv;
    logic                 s1_ok;
    logic [7:0]           s1_border;
    logic [8*NLAYERS-1:0] s1_ts;
    logic [NLAYERS-1:0]   s1_ts_en;
    logic                 s1_hvpix;
    logic                 s1_hvtspix;
    logic                 s1_nogfx;
    logic [PRIO_W-1:0]    s1_prio;
    logic                 s1_ls;
    logic [1:0]           s1_hires;

    // Capture decoded pixel plus all side-band inputs aligned to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_pix     <= '0;
            s1_pv      <= 1'b0;
            s1_ok      <= 1'b0;
            s1_border  <= '0;
            s1_ts      <= '0;
            s1_ts_en   <= '0;
            s1_hvpix   <= 1'b0;
            s1_hvtspix <= 1'b0;
            s1_nogfx   <= 1'b0;
            s1_prio    <= '0;
            s1_ls      <= 1'b0;
            s1_hires   <= '0;
        end else if (c1) begin
            s1_valid   <= 1'b1;
            s1_pix     <= dec_pix;
            s1_pv      <= dec_pv;
            s1_ok      <= dec_ok;
            s1_border  <= border_in;
            s1_ts      <= ts_data;
            s1_ts_en   <= ts_en;
            s1_hvpix   <= hvpix;
            s1_hvtspix <= hvtspix;
            s1_nogfx   <= nogfx;
            s1_prio    <= gfx_prio;
            s1_ls      <= line_start;
            s1_hires   <= hires_eff;
        end
    end

    // ---------------- composite ----------------
    logic [NLAYERS-1:0] lay_vis;
    logic               gfx_vis;
    logic [PRIO_W-1:0]  gfx_pos;
    logic [7:0]         video;

    for (genvar i = 0; i < NLAYERS; i++) begin : g_vis
        assign lay_vis[i] = s1_ts_en[i] && (|s1_ts[8*i +: 4]) && (s1_hvpix || s1_hvtspix);
    end

    assign gfx_vis = s1_hvpix && !s1_nogfx && s1_pv;
    assign gfx_pos = (s1_prio > GFX_MAX) ? GFX_MAX : s1_prio;

    // Priority resolve: later assignments win, so paint bottom of stack first
    always_comb begin
        video = (s1_hvpix && !s1_nogfx && s1_ok) ? s1_pix : s1_border;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (i >= int'(gfx_pos) && lay_vis[i]) video = s1_ts[8*i +: 8];
        end
        if (gfx_vis) video = s1_pix;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (i < int'(gfx_pos) && lay_vis[i]) video = s1_ts[8*i +: 8];
        end
    end

    // ---------------- packing ----------------
    logic [1:0] phase;
    logic [1:0] pack_mode;
    logic [5:0] hold;
    logic [1:0] ph_eff;

    // A new line or a hires change abandons any partially packed byte
    assign ph_eff = (s1_ls || (s1_hires != pack_mode)) ? 2'd0 : phase;

    // Pack 1/2/4 pixels per byte; valid pulses only on a completed byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vplex_out   <= '0;
            vplex_valid <= 1'b0;
            phase       <= '0;
            pack_mode   <= '0;
            hold        <= '0;
        end else begin
            vplex_valid <= 1'b0;
            if (c1 && s1_valid) begin
                pack_mode <= s1_hires;
                case (s1_hires)
                    2'd1: begin
                        if (ph_eff == 2'd0) begin
                            hold  <= {2'b00, video[3:0]};
                            phase <= 2'd1;
                        end else begin
                            vplex_out   <= {hold[3:0], video[3:0]};
                            vplex_valid <= 1'b1;
                            phase       <= 2'd0;
                        end
                    end
                    2'd2: begin
                        hold <= {hold[3:0], video[1:0]};
                        if (ph_eff == 2'd3) begin
                            vplex_out   <= {hold[5:0], video[1:0]};
                            vplex_valid <= 1'b1;
                            phase       <= 2'd0;
                        end else begin
                            phase <= ph_eff + 2'd1;
                        end
                    end
                    default: begin
                        vplex_out   <= video;
                        vplex_valid <= 1'b1;
                        phase       <= 2'd0;
                    end
                endcase
            end
        end
    end

    // ---------------- flash ----------------
    logic [FC_W-1:0] flash_cnt;
    logic            live;

    // Frame counter for ZX flash; the first edge after reset release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
            flash_out <= 1'b0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (frame_start && live) begin
                if (flash_cnt == FC_LAST) begin
                    flash_cnt <= '0;
                    flash_out <= ~flash_out;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
